// File: rtl/game_pkg.sv
// Shared types and constants for Red Light, Green Light game control.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package game_pkg;

  // Round/phase sequencer states
  typedef enum logic [2:0] {
    IDLE,
    READY,
    GREEN,
    RED,
    ROUND_OVER,
    GAME_OVER
  } state_t;

  // Round result as shown to the renderer
  typedef enum logic [2:0] {
    W_NONE   = 3'd0,
    W_PLAYER = 3'd1,
    W_AI1    = 3'd2,
    W_AI2    = 3'd3,
    W_AI3    = 3'd4,
    W_FOUL   = 3'd5
  } winner_t;

  // Track geometry shared with car_manager
  localparam int unsigned FINISH_X = 580;
  localparam int unsigned START_X  = 50;

  // Score counters stick at their maximum instead of wrapping
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Timer tick source: one-cycle pulse on the last cycle of every TICK_CYCLES window.
// Latency: first pulse TICK_CYCLES cycles after reset is released.
// Backpressure: none; free-running while reset is low.
module tick_gen #(
  parameter int unsigned TICK_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  if (TICK_CYCLES < 1) begin : g_bad_tick_cycles
    $error("tick_gen: TICK_CYCLES must be at least 1");
  end

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Wrap the cycle counter at the end of each window
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  // Cycle counter; reset also realigns the window to the caller's phase start
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/light_round_controller.sv
// Round/phase sequencer for Red Light, Green Light: light phases, foul policing, finish, scores.
// Latency: outputs registered, reflect a trigger one cycle after it is seen on the inputs.
// Backpressure: none; start is edge-detected and ignored outside IDLE/ROUND_OVER/GAME_OVER.
// Optional build macro LIGHT_WARN_EN adds the yellow end-of-green warning.
module light_round_controller
  import game_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 5_000_000,
  parameter int unsigned READY_TICKS = 20,
  parameter int unsigned GREEN_BASE  = 20,
  parameter int unsigned RED_BASE    = 15,
  parameter int unsigned RED_GRACE   = 3,
  parameter int unsigned WARN_TICKS  = 5,
  parameter int unsigned FINISH_X    = game_pkg::FINISH_X,
  parameter int unsigned MAX_ROUNDS  = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] rand_val,
  input  logic        move_up,
  input  logic        move_down,
  input  logic        move_forward,
  input  logic [9:0]  player_x,
  input  logic [9:0]  ai1_x,
  input  logic [9:0]  ai2_x,
  input  logic [9:0]  ai3_x,
  output logic        game_active,
  output logic        light_green,
  output logic        light_yellow,
  output logic [2:0]  winner,
  output logic [2:0]  round_num,
  output logic [3:0]  player_score,
  output logic [3:0]  ai_score,
  output logic        game_over
);

  // Phase durations are held in 8 bits, so the longest randomised phase must fit
  if (GREEN_BASE + 15 > 255 || GREEN_BASE < 1) begin : g_bad_green
    $error("light_round_controller: GREEN_BASE must be 1..240");
  end
  if (RED_BASE + 15 > 255 || RED_BASE < 1) begin : g_bad_red
    $error("light_round_controller: RED_BASE must be 1..240");
  end
  if (READY_TICKS < 1 || READY_TICKS > 255) begin : g_bad_ready
    $error("light_round_controller: READY_TICKS must be 1..255");
  end
  if (RED_GRACE > 255 || WARN_TICKS > 255) begin : g_bad_grace
    $error("light_round_controller: RED_GRACE and WARN_TICKS must fit in 8 bits");
  end
  if (MAX_ROUNDS < 1 || MAX_ROUNDS > 7) begin : g_bad_rounds
    $error("light_round_controller: MAX_ROUNDS must be 1..7");
  end

  state_t      state_q;
  state_t      state_d;
  logic        start_q;
  logic        start_edge;
  logic        tick;
  logic        tick_rst;
  logic        phase_restart;
  logic        phase_done;
  logic        timed_state;
  logic [7:0]  timer_q;
  logic [7:0]  dur_q;
  logic [7:0]  green_dur;
  logic [7:0]  red_dur;
  logic        any_move;
  logic        foul;
  logic        finish_any;
  winner_t     finish_winner;
  winner_t     round_winner;
  winner_t     winner_q;
  logic [2:0]  round_q;
  logic [3:0]  pscore_q;
  logic [3:0]  ascore_q;
  logic        game_active_q;
  logic        light_green_q;
  logic        game_over_q;
  logic        unused_rand;

  // Only the top nibble of the LFSR feeds the phase lengths
  assign unused_rand = ^rand_val[11:0];

  assign start_edge  = start & ~start_q;
  assign green_dur   = 8'(GREEN_BASE) + {4'd0, rand_val[15:12]};
  assign red_dur     = 8'(RED_BASE) + {4'd0, rand_val[15:12]};
  assign timed_state = (state_q == READY) || (state_q == GREEN) || (state_q == RED);
  assign phase_done  = tick && (timer_q == dur_q - 8'd1);
  assign any_move    = move_up | move_down | move_forward;
  assign foul        = (state_q == RED) && any_move && (timer_q >= 8'(RED_GRACE));

  // Finish detection with fixed priority player > ai1 > ai2 > ai3
  always_comb begin
    finish_winner = W_NONE;
    if (player_x >= 10'(FINISH_X)) begin
      finish_winner = W_PLAYER;
    end else if (ai1_x >= 10'(FINISH_X)) begin
      finish_winner = W_AI1;
    end else if (ai2_x >= 10'(FINISH_X)) begin
      finish_winner = W_AI2;
    end else if (ai3_x >= 10'(FINISH_X)) begin
      finish_winner = W_AI3;
    end
  end

  assign finish_any   = (finish_winner != W_NONE);
  assign round_winner = finish_any ? finish_winner : W_FOUL;

  // Next-state selection; finish outranks both foul and phase expiry
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (start_edge) state_d = READY;
      READY:      if (phase_done) state_d = GREEN;
      GREEN: begin
        if (finish_any)      state_d = ROUND_OVER;
        else if (phase_done) state_d = RED;
      end
      RED: begin
        if (finish_any || foul) state_d = ROUND_OVER;
        else if (phase_done)    state_d = GREEN;
      end
      ROUND_OVER: begin
        if (start_edge) state_d = (round_q == 3'(MAX_ROUNDS)) ? GAME_OVER : READY;
      end
      GAME_OVER:  if (start_edge) state_d = READY;
      default:    state_d = IDLE;
    endcase
  end

  // Every state change restarts the tick window so each phase lasts whole ticks
  assign phase_restart = (state_d != state_q);
  assign tick_rst      = reset | phase_restart;

  tick_gen #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick_gen (
    .clk   (clk),
    .reset (tick_rst),
    .tick  (tick)
  );

  // Sequencer registers: state, phase timer, latched duration, round bookkeeping, outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      start_q       <= 1'b0;
      timer_q       <= '0;
      dur_q         <= '0;
      winner_q      <= W_NONE;
      round_q       <= 3'd1;
      pscore_q      <= '0;
      ascore_q      <= '0;
      game_active_q <= 1'b0;
      light_green_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      start_q       <= start;
      state_q       <= state_d;
      game_active_q <= (state_d == GREEN) || (state_d == RED);
      light_green_q <= (state_d == GREEN);
      game_over_q   <= (state_d == GAME_OVER);

      if (phase_restart) begin
        timer_q <= '0;
      end else if (tick && timed_state) begin
        timer_q <= timer_q + 8'd1;
      end

      if (phase_restart) begin
        unique case (state_d)
          READY: begin
            dur_q <= 8'(READY_TICKS);
            if (state_q == ROUND_OVER) begin
              round_q <= round_q + 3'd1;
            end else if (state_q == GAME_OVER) begin
              round_q  <= 3'd1;
              pscore_q <= '0;
              ascore_q <= '0;
              winner_q <= W_NONE;
            end
          end
          GREEN: begin
            dur_q    <= green_dur;
            winner_q <= W_NONE;
          end
          RED: begin
            dur_q <= red_dur;
          end
          ROUND_OVER: begin
            winner_q <= round_winner;
            if (round_winner == W_PLAYER) begin
              pscore_q <= sat_inc4(pscore_q);
            end else begin
              ascore_q <= sat_inc4(ascore_q);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef LIGHT_WARN_EN
  logic       light_yellow_q;
  logic [7:0] remain_after_tick;

  assign remain_after_tick = dur_q - timer_q - 8'd1;

  // Yellow tracks the green ticks still to run, updated on entry and on each tick
  always_ff @(posedge clk) begin
    if (reset) begin
      light_yellow_q <= 1'b0;
    end else if (state_d != GREEN) begin
      light_yellow_q <= 1'b0;
    end else if (state_q != GREEN) begin
      light_yellow_q <= (green_dur <= 8'(WARN_TICKS));
    end else if (tick) begin
      light_yellow_q <= (remain_after_tick <= 8'(WARN_TICKS));
    end
  end

  assign light_yellow = light_yellow_q;
`else
  assign light_yellow = 1'b0;
`endif

  assign game_active  = game_active_q;
  assign light_green  = light_green_q;
  assign winner       = winner_q;
  assign round_num    = round_q;
  assign player_score = pscore_q;
  assign ai_score     = ascore_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_light_round_controller.sv
// Directed bench for light_round_controller with short tick/phase parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_light_round_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] rand_val;
  logic        move_up, move_down, move_forward;
  logic [9:0]  player_x, ai1_x, ai2_x, ai3_x;
  logic        game_active, light_green, light_yellow, game_over;
  logic [2:0]  winner, round_num;
  logic [3:0]  player_score, ai_score;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef LIGHT_WARN_EN
  localparam int YEL = 1;
`else
  localparam int YEL = 0;
`endif

  always #5 clk = ~clk;

  light_round_controller #(
    .TICK_CYCLES (4),
    .READY_TICKS (2),
    .GREEN_BASE  (3),
    .RED_BASE    (2),
    .RED_GRACE   (1),
    .WARN_TICKS  (1),
    .FINISH_X    (580),
    .MAX_ROUNDS  (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rand_val     (rand_val),
    .move_up      (move_up),
    .move_down    (move_down),
    .move_forward (move_forward),
    .player_x     (player_x),
    .ai1_x        (ai1_x),
    .ai2_x        (ai2_x),
    .ai3_x        (ai3_x),
    .game_active  (game_active),
    .light_green  (light_green),
    .light_yellow (light_yellow),
    .winner       (winner),
    .round_num    (round_num),
    .player_score (player_score),
    .ai_score     (ai_score),
    .game_over    (game_over)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic clear_cars();
    player_x = 10'd50; ai1_x = 10'd50; ai2_x = 10'd50; ai3_x = 10'd50;
    move_up = 1'b0; move_down = 1'b0; move_forward = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rand_val = 16'h0000;
    clear_cars();
    step(2);
    reset = 1'b0;
    chk("rst_active", game_active, 0);
    chk("rst_round", round_num, 1);
    chk("rst_winner", winner, 0);
    chk("rst_pscore", player_score, 0);
    chk("rst_ascore", ai_score, 0);
    chk("rst_gover", game_over, 0);
    chk("rst_green", light_green, 0);
    chk("rst_yellow", light_yellow, 0);
    step(1);
    chk("idle_hold", game_active, 0);

    // Round 1: READY 8 cycles, GREEN 12 cycles, foul after grace in RED
    pulse_start();
    chk("ready_active", game_active, 0);
    step(7);
    chk("ready_7cyc", game_active, 0);
    step(1);
    chk("green_rise", game_active, 1);
    chk("green_light", light_green, 1);
    chk("green_yel_early", light_yellow, 0);
    step(7);
    chk("green_yel_pre", light_yellow, 0);
    step(1);
    chk("green_yel_warn", light_yellow, YEL);
    step(3);
    chk("green_11cyc", light_green, 1);
    step(1);
    chk("red_green_off", light_green, 0);
    chk("red_active", game_active, 1);
    chk("red_yellow_off", light_yellow, 0);
    move_forward = 1'b1;
    step(4);
    chk("grace_no_foul", winner, 0);
    chk("grace_active", game_active, 1);
    step(1);
    chk("foul_winner", winner, 5);
    chk("foul_ascore", ai_score, 1);
    chk("foul_pscore", player_score, 0);
    chk("foul_inactive", game_active, 0);
    clear_cars();

    // Round 2: latched green length, ignored start, finish beats foul in RED
    pulse_start();
    chk("r2_round", round_num, 2);
    chk("r2_winner_hold", winner, 5);
    rand_val = 16'h2000;
    step(8);
    chk("r2_green", game_active, 1);
    chk("r2_winner_clr", winner, 0);
    rand_val = 16'h0000;
    step(5);
    pulse_start();
    chk("start_ignored", light_green, 1);
    chk("start_ign_round", round_num, 2);
    step(13);
    chk("green_latched", light_green, 1);
    step(1);
    chk("r2_red", light_green, 0);
    chk("r2_red_active", game_active, 1);
    step(4);
    move_forward = 1'b1; player_x = 10'd580; ai1_x = 10'd590;
    step(1);
    chk("fin_foul_winner", winner, 1);
    chk("fin_foul_pscore", player_score, 1);
    chk("fin_foul_ascore", ai_score, 1);
    chk("fin_foul_active", game_active, 0);
    clear_cars();

    // Last round done: next start ends the game, the one after restarts it
    pulse_start();
    chk("gover_flag", game_over, 1);
    chk("gover_active", game_active, 0);
    step(1);
    pulse_start();
    chk("new_gover", game_over, 0);
    chk("new_round", round_num, 1);
    chk("new_pscore", player_score, 0);
    chk("new_ascore", ai_score, 0);
    chk("new_winner", winner, 0);

    // Player and ai1 finish together in GREEN
    step(8);
    chk("g2_green", game_active, 1);
    player_x = 10'd580; ai1_x = 10'd590;
    step(1);
    chk("prio_winner", winner, 1);
    chk("prio_pscore", player_score, 1);
    chk("prio_active", game_active, 0);
    chk("prio_green", light_green, 0);
    clear_cars();

    // Reset in RED of round 2
    pulse_start();
    chk("g2r2_round", round_num, 2);
    step(8);
    step(12);
    chk("g2r2_red_green", light_green, 0);
    chk("g2r2_red_active", game_active, 1);
    reset = 1'b1;
    step(1);
    chk("mid_rst_active", game_active, 0);
    chk("mid_rst_round", round_num, 1);
    chk("mid_rst_pscore", player_score, 0);
    reset = 1'b0;
    step(2);
    chk("post_rst_idle", game_active, 0);

    // ai2 and ai3 finish together: ai2 wins
    pulse_start();
    step(8);
    chk("post_rst_green", game_active, 1);
    ai2_x = 10'd600; ai3_x = 10'd700;
    step(1);
    chk("ai_prio_winner", winner, 3);
    chk("ai_prio_ascore", ai_score, 1);
    chk("ai_prio_pscore", player_score, 0);
    clear_cars();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
